scrambler_tx: RTL and testbench
===============================

Name: scrambler_tx

Overview:
Transmit-side serial scrambler for the USB4 logical layer; inverse of the lane descrambler. Takes one data bit per enabled clock and XORs it with a 23-bit Fibonacci LFSR keystream (x^23+x^21+x^16+x^8+x^5+x^2+1). Sync-header bits at the start of each symbol pass through unscrambled, and the LFSR does not advance on them. Sits between the 64b/66b encoder and the serializer, one instance per lane.

Parameters:
SEED, 23'h178225, LFSR value loaded on scr_rst
TAP_MASK, 23'h508092, feedback taps (bits 22,20,15,7,4,1)
SYMBOL_BITS, 66, bits per symbol including header; must be >= 2
HDR_BITS, 2, unscrambled header bits at start of each symbol; must be < SYMBOL_BITS

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
data_in  input  1  plaintext bit, sampled when enable=1
enable  input  1  bit-valid strobe
scr_rst  input  1  synchronous reseed / symbol realign, priority over enable
scrambled_out  output  1  registered scrambled bit
out_valid  output  1  scrambled_out carries a new bit this cycle
sym_start  output  1  high with out_valid on first header bit of a symbol
seeded  output  1  high once scr_rst has been seen since reset

Behaviour:
- Reset (rst=0, async): lfsr=SEED; bit counter pos=0; state=IDLE; scrambled_out=0; out_valid=0; sym_start=0; seeded=0.
- States:
  - IDLE: enable is ignored; out_valid=0.
  - RUN: entered only via scr_rst.
- scr_rst=1 (any state, any enable): lfsr<=SEED, pos<=0, state<=RUN, seeded<=1, out_valid<=0, sym_start<=0, scrambled_out holds. data_in is not consumed that cycle.
- RUN, enable=1, scr_rst=0: outputs are registered with 1-cycle latency; the bit on data_in at edge N appears at edge N+1.
  - pos < HDR_BITS: scrambled_out<=data_in; lfsr holds.
  - pos >= HDR_BITS: scrambled_out<=data_in ^ lfsr[22]; lfsr<={lfsr[21:0], ^(lfsr & TAP_MASK)}.
  - out_valid<=1; sym_start<=(pos==0).
  - pos<=(pos==SYMBOL_BITS-1) ? 0 : pos+1.
- RUN, enable=0: lfsr and pos hold; out_valid<=0; sym_start<=0; scrambled_out holds last value.
- Counter width: $clog2(SYMBOL_BITS). Wraps exactly at SYMBOL_BITS-1, with no gaps.
- First 23 keystream bits after seeding are SEED[22] down to SEED[0]; feedback bits follow.
- Default-SEED keystream begins 0,0,1,0,1,1,1,1,0,0,0,0,0,1,0,0,0,1,0,0,1,0,1.
- Reset mid-stream returns to IDLE; data is not scrambled until the next scr_rst.
- Scrambling is self-inverse, so a matching descrambler seeded identically recovers data_in.

Optional Feature:
SCR_BYPASS_EN:
- Defined: adds input port bypass (1 bit). While bypass=1 in RUN with enable=1, scrambled_out<=data_in for every bit position. The LFSR still advances on non-header positions, so the keystream stays aligned with the far end.
- Undefined: no bypass port; behaviour exactly as above.

Test Plan:
- Reset values: rst=0 then release, enable=1, no scr_rst, 10 cycles -> out_valid=0, scrambled_out=0, seeded=0.
- Header and keystream: scr_rst pulse; enable=1; data_in=1,0 then 23 zeros -> scrambled_out=1,0,0,0,1,0,1,1,1,1,0,0,0,0,0,1,0,0,0,1,0,0,1,0,1. sym_start=1 on the first output only.
- Symbol wrap: 132 enabled bits of data_in=0 after scr_rst -> sym_start=1 on output bits 0 and 66. Output bits 66 and 67 are 0 (header) and the LFSR does not step on them. Bit 68 equals keystream bit 64.
- Enable gaps: scr_rst, then alternate enable 1/0 over 46 cycles with data_in=0 -> the 23 valid outputs match the contiguous sequence above. out_valid=0 in gap cycles and scrambled_out is held.
- scr_rst mid-symbol: at pos=40 assert scr_rst together with enable=1 -> no output that cycle; the next enabled bit restarts at pos=0 with sym_start=1 and keystream from SEED.
- Loopback: random 1000 bits through scrambler_tx into a descrambler seeded on the same cycle -> recovered stream equals data_in.

Source files
------------

// File: rtl/scrambler_tx.sv
// Serial 23-bit LFSR scrambler with unscrambled sync-header bits, one lane.
// Optional SCR_BYPASS_EN macro adds a bypass input that forwards plaintext.
module scrambler_tx #(
    parameter logic [22:0] SEED        = 23'h178225,
    parameter logic [22:0] TAP_MASK    = 23'h508092,
    parameter int unsigned SYMBOL_BITS = 66,
    parameter int unsigned HDR_BITS    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic data_in,
    input  logic enable,
    input  logic scr_rst,
    output logic scrambled_out,
    output logic out_valid,
    output logic sym_start,
    output logic seeded
`ifdef SCR_BYPASS_EN
    ,
    input  logic bypass
`endif
);

    localparam int PW = $clog2(SYMBOL_BITS);
    localparam logic [PW-1:0] LAST = PW'(SYMBOL_BITS - 1);
    localparam logic [PW-1:0] HDR  = PW'(HDR_BITS);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state_q, state_d;
    logic [22:0]   lfsr_q, lfsr_d;
    logic [PW-1:0] pos_q, pos_d;
    logic          out_q, out_d;
    logic          valid_q, valid_d;
    logic          sym_q, sym_d;
    logic          seeded_q, seeded_d;

    logic hdr;
    logic fb;
    logic byp;

    assign hdr = (pos_q < HDR);
    assign fb  = ^(lfsr_q & TAP_MASK);

`ifdef SCR_BYPASS_EN
    assign byp = bypass;
`else
    assign byp = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        pos_d    = pos_q;
        out_d    = out_q;
        valid_d  = 1'b0;
        sym_d    = 1'b0;
        seeded_d = seeded_q;
        if (scr_rst) begin
            state_d  = RUN;
            lfsr_d   = SEED;
            pos_d    = '0;
            seeded_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                RUN: begin
                    if (enable) begin
                        // Keystream is consumed on payload bits even in bypass
                        out_d   = data_in ^ (lfsr_q[22] & ~hdr & ~byp);
                        valid_d = 1'b1;
                        sym_d   = (pos_q == '0);
                        pos_d   = (pos_q == LAST) ? '0 : pos_q + PW'(1);
                        if (!hdr) begin
                            lfsr_d = {lfsr_q[21:0], fb};
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            lfsr_q   <= SEED;
            pos_q    <= '0;
            out_q    <= 1'b0;
            valid_q  <= 1'b0;
            sym_q    <= 1'b0;
            seeded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            pos_q    <= pos_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            sym_q    <= sym_d;
            seeded_q <= seeded_d;
        end
    end

    assign scrambled_out = out_q;
    assign out_valid     = valid_q;
    assign sym_start     = sym_q;
    assign seeded        = seeded_q;

endmodule

// File: tb/tb_scrambler_tx.sv
// Directed bench for scrambler_tx: reset, keystream, wrap, gaps, realign, loopback.
module tb_scrambler_tx;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic data_in = 1'b0;
    logic enable = 1'b0;
    logic scr_rst = 1'b0;
    logic scrambled_out;
    logic out_valid;
    logic sym_start;
    logic seeded;
`ifdef SCR_BYPASS_EN
    logic bypass = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    logic ks [0:1199];
    logic exp_last;

    typedef struct {
        logic en;
        logic d;
        logic sr;
        logic v;
        logic o;
        logic s;
    } vec_t;

    vec_t tv[$];

    scrambler_tx dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .enable(enable),
        .scr_rst(scr_rst),
        .scrambled_out(scrambled_out),
        .out_valid(out_valid),
        .sym_start(sym_start),
        .seeded(seeded)
`ifdef SCR_BYPASS_EN
        ,
        .bypass(bypass)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic en, logic d, logic sr,
                                logic v, logic o, logic s);
        vec_t r;
        r.en = en;
        r.d  = d;
        r.sr = sr;
        r.v  = v;
        r.o  = o;
        r.s  = s;
        return r;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic d, input logic sr);
        enable  = en;
        data_in = d;
        scr_rst = sr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string tag, input logic v,
                        input logic o, input logic s);
        chk({tag, ".valid"}, out_valid, v);
        chk({tag, ".out"}, scrambled_out, o);
        chk({tag, ".sym"}, sym_start, s);
    endtask

    initial begin
        logic [22:0] sd;
        logic [24:0] hv;
        int cnt;
        int p;
        int kidx;
        logic d;
        logic e;

        sd = 23'h178225;
        for (int i = 0; i < 23; i++) ks[i] = sd[22-i];
        for (int n = 0; n + 23 < 1200; n++)
            ks[n+23] = ks[n] ^ ks[n+2] ^ ks[n+7] ^ ks[n+15] ^ ks[n+18] ^ ks[n+21];

        // reset behaviour
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold.valid", out_valid, 1'b0);
        chk("rst_hold.seeded", seeded, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0);
            chk3($sformatf("idle%0d", i), 1'b0, 1'b0, 1'b0);
            chk($sformatf("idle%0d.seeded", i), seeded, 1'b0);
        end

        // header then default-seed keystream, hand table
        hv = 25'b1000101111000001000100101;
        tv.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tv.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, hv[24], 1'b1));
        for (int i = 1; i < 25; i++)
            tv.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, hv[24-i], 1'b0));
        tv.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        tv.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        foreach (tv[i]) begin
            step(tv[i].en, tv[i].d, tv[i].sr);
            chk3($sformatf("tab%0d", i), tv[i].v, tv[i].o, tv[i].s);
        end
        chk("tab.seeded", seeded, 1'b1);
        exp_last = 1'b1;

        // symbol wrap over two symbols
        step(1'b1, 1'b0, 1'b1);
        chk3("wrap_rst", 1'b0, exp_last, 1'b0);
        for (int i = 0; i < 132; i++) begin
            p = i % 66;
            e = (p < 2) ? 1'b0 : ks[(i / 66) * 64 + p - 2];
            step(1'b1, 1'b0, 1'b0);
            chk3($sformatf("wrap%0d", i), 1'b1, e, (p == 0));
            exp_last = e;
        end

        // enable gaps
        step(1'b0, 1'b0, 1'b1);
        cnt = 0;
        for (int c = 0; c < 46; c++) begin
            if (c % 2 == 0) begin
                e = (cnt < 2) ? 1'b0 : ks[cnt-2];
                step(1'b1, 1'b0, 1'b0);
                chk3($sformatf("gap%0d", c), 1'b1, e, (cnt == 0));
                exp_last = e;
                cnt++;
            end else begin
                step(1'b0, 1'b1, 1'b0);
                chk3($sformatf("gap%0d", c), 1'b0, exp_last, 1'b0);
            end
        end

        // scr_rst mid-symbol with enable high
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            d = 1'($urandom_range(0, 1));
            e = d ^ ((i < 2) ? 1'b0 : ks[i-2]);
            step(1'b1, d, 1'b0);
            chk3($sformatf("mid%0d", i), 1'b1, e, (i == 0));
            exp_last = e;
        end
        step(1'b1, 1'b1, 1'b1);
        chk3("mid_rst", 1'b0, exp_last, 1'b0);
        for (int i = 0; i < 6; i++) begin
            e = (i < 2) ? 1'b0 : ks[i-2];
            step(1'b1, 1'b0, 1'b0);
            chk3($sformatf("realign%0d", i), 1'b1, e, (i == 0));
            exp_last = e;
        end

`ifdef SCR_BYPASS_EN
        step(1'b0, 1'b0, 1'b1);
        bypass = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d = 1'($urandom_range(0, 1));
            step(1'b1, d, 1'b0);
            chk3($sformatf("byp%0d", i), 1'b1, d, (i == 0));
        end
        bypass = 1'b0;
        for (int i = 10; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk3($sformatf("byp%0d", i), 1'b1, ks[i-2], 1'b0);
        end
`endif

        // loopback through a bench-side descrambler
        step(1'b0, 1'b0, 1'b1);
        p = 0;
        kidx = 0;
        for (int i = 0; i < 1000; i++) begin
            d = 1'($urandom_range(0, 1));
            step(1'b1, d, 1'b0);
            if (p < 2) begin
                e = scrambled_out;
            end else begin
                e = scrambled_out ^ ks[kidx];
                kidx++;
            end
            chk($sformatf("loop%0d", i), e, d);
            p = (p == 65) ? 0 : p + 1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
